lane_read_sequencer: RTL and testbench

Sequences the 25 lane reads of a 5×5×64 state held as 64 slice words of 25 bits. For each lane it drives the lane-reader strobe and lane index, captures the returned 64-bit lane after a fixed latency, and offers it downstream on a valid/ready handshake. It sits between the top-level control, which issues `start` and waits for `done`, and the lane reader, which produces one lane per strobe.

---
 rtl/lane_seq_pkg.sv | 8 +
 rtl/lane_wait_timer.sv | 19 +
 rtl/lane_read_sequencer.sv | 109 ++++++++++
 tb/tb_lane_read_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_seq_pkg.sv
// lane_seq_pkg: shared state encoding and default sizes for the lane read sequencer
// Contents: lane_seq_state_t FSM states, LANE_SEQ_NUM_LANES, LANE_SEQ_LANE_W, LANE_SEQ_TMR_W
package lane_seq_pkg;
  typedef enum logic [2:0] {IDLE, STROBE, WAIT, OFFER, DONE} lane_seq_state_t;
  localparam int LANE_SEQ_NUM_LANES = 25;
  localparam int LANE_SEQ_LANE_W = 64;
  localparam int LANE_SEQ_TMR_W = 3;
endpackage

// File: rtl/lane_wait_timer.sv
// lane_wait_timer: loadable down-counter that flags the last cycle of the lane read latency
// Ports: clk, rst_n (async, active low); load/lat reload the count; expire is high while the count is 1
module lane_wait_timer
  import lane_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [LANE_SEQ_TMR_W-1:0] lat,
  output logic                      expire
);
  logic [LANE_SEQ_TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? lat : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire = cnt_q == LANE_SEQ_TMR_W'(1);
endmodule

// File: rtl/lane_read_sequencer.sv
// lane_read_sequencer: sweeps every lane through the lane reader and offers each captured lane on valid/ready
// Ports: clk, rst_n (async, active low); start begins a sweep (IDLE only);
//        rd_strobe/rd_idx/rd_lane talk to the lane reader; out_valid/out_ready/out_lane/out_idx go downstream;
//        busy/done report to control; parity (XOR of the sweep) exists only with LANE_SEQ_PARITY_EN defined
module lane_read_sequencer
  import lane_seq_pkg::*;
#(
  parameter int NUM_LANES = LANE_SEQ_NUM_LANES,
  parameter int LANE_W = LANE_SEQ_LANE_W,
  parameter int RD_LAT = 1,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_strobe,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [LANE_W-1:0] rd_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
`ifdef LANE_SEQ_PARITY_EN
  ,
  output logic [LANE_W-1:0] parity
`endif
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LANES - 1);
  lane_seq_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [LANE_W-1:0] out_lane_q, out_lane_d;
  logic rd_strobe_q, out_valid_q, busy_q, done_q;
  logic load, expire, cap;
  lane_wait_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .lat   (LANE_SEQ_TMR_W'(RD_LAT)),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    load = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        idx_d = '0;
        state_d = STROBE;
      end
      STROBE: begin
        load = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (expire) begin
        cap = 1'b1;
        state_d = OFFER;
      end
      OFFER: if (out_ready) begin
        state_d = idx_q == LAST ? DONE : STROBE;
        idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_lane_d = cap ? rd_lane : out_lane_q;
    out_idx_d = cap ? idx_q : out_idx_q;
  end
  // Outputs are registered from the next state so they line up with state_q without decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      out_lane_q <= '0;
      out_idx_q <= '0;
      rd_strobe_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_lane_q <= out_lane_d;
      out_idx_q <= out_idx_d;
      rd_strobe_q <= state_d == STROBE;
      out_valid_q <= state_d == OFFER;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end
  assign rd_strobe = rd_strobe_q;
  assign rd_idx = idx_q;
  assign out_valid = out_valid_q;
  assign out_lane = out_lane_q;
  assign out_idx = out_idx_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef LANE_SEQ_PARITY_EN
  logic [LANE_W-1:0] parity_q, parity_d;
  always_comb parity_d = (state_q == IDLE && start) ? '0 : (cap ? parity_q ^ rd_lane : parity_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= '0;
    else parity_q <= parity_d;
  end
  assign parity = parity_q;
`endif
endmodule

// File: tb/tb_lane_read_sequencer.sv
// tb_lane_read_sequencer: scoreboard bench for lane_read_sequencer at RD_LAT=1 and RD_LAT=3
module tb_lane_read_sequencer;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [2];
  logic rdy [2];
  logic strb [2];
  logic [4:0] ridx [2];
  logic [63:0] rlane [2];
  logic ov [2];
  logic [63:0] olane [2];
  logic [4:0] oidx [2];
  logic busy [2];
  logic done [2];
`ifdef LANE_SEQ_PARITY_EN
  logic [63:0] par [2];
  logic [63:0] done_par;
`endif
  int total = 0;
  int bad = 0;
  int mode = 0;
  int sel = 0;
  int cyc, nidx, ndone, done_cyc, lowrun, mingap;
  logic [68:0] expq [$];
  logic [68:0] obsq [$];
  logic [63:0] p1;
  logic [63:0] p3 [3];
  logic ps [2];

  always #5 clk = ~clk;

  lane_read_sequencer #(.RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rd_strobe(strb[0]), .rd_idx(ridx[0]),
    .rd_lane(rlane[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_lane(olane[0]),
    .out_idx(oidx[0]), .busy(busy[0]), .done(done[0])
`ifdef LANE_SEQ_PARITY_EN
    , .parity(par[0])
`endif
  );
  lane_read_sequencer #(.RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rd_strobe(strb[1]), .rd_idx(ridx[1]),
    .rd_lane(rlane[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_lane(olane[1]),
    .out_idx(oidx[1]), .busy(busy[1]), .done(done[1])
`ifdef LANE_SEQ_PARITY_EN
    , .parity(par[1])
`endif
  );

  function automatic logic [63:0] pat(input logic [4:0] i);
    logic [63:0] one = 64'h1;
    return mode == 1 ? one << i : {8{3'b000, i}};
  endfunction

  // Reader models: a strobe rising edge yields the lane pattern RD_LAT cycles later, junk otherwise.
  always @(posedge clk) begin
    ps[0] <= strb[0];
    ps[1] <= strb[1];
    p1 <= (strb[0] && !ps[0]) ? pat(ridx[0]) : JUNK;
    p3[0] <= (strb[1] && !ps[1]) ? pat(ridx[1]) : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rlane[0] = p1;
  assign rlane[1] = p3[2];

  task automatic tick();
    if (ov[sel] && rdy[sel]) obsq.push_back({oidx[sel], olane[sel]});
    @(negedge clk);
    cyc++;
    if (strb[sel]) begin
      if (nidx > 0 && lowrun < mingap) mingap = lowrun;
      expq.push_back({5'(nidx), pat(5'(nidx))});
      nidx++;
      lowrun = 0;
    end else lowrun++;
    if (done[sel]) begin
      ndone++;
      done_cyc = cyc;
`ifdef LANE_SEQ_PARITY_EN
      done_par = par[sel];
`endif
    end
  endtask

  task automatic kick();
    expq.delete();
    obsq.delete();
    cyc = 0;
    nidx = 0;
    ndone = 0;
    done_cyc = -1;
    lowrun = 0;
    mingap = 99;
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
  endtask

  task automatic finish_sweep();
    for (int i = 0; i < 400 && ndone == 0; i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    start[0] = 1'b0; start[1] = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({strb[d], ridx[d], ov[d], olane[d], oidx[d], busy[d], done[d]} !== 78'd0) begin
        bad++;
        $display("FAIL reset_vals dut%0d: got %h want 0", d, {strb[d], ridx[d], ov[d], olane[d], oidx[d], busy[d], done[d]});
      end
`ifdef LANE_SEQ_PARITY_EN
      total++;
      if (par[d] !== 64'd0) begin bad++; $display("FAIL reset_parity dut%0d: got %h want 0", d, par[d]); end
`endif
    end
    rst_n = 1'b1;
    sel = 0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy[d], strb[d], ov[d], done[d]} !== 4'd0) begin
        bad++;
        $display("FAIL idle_after_reset dut%0d: got %b want 0000", d, {busy[d], strb[d], ov[d], done[d]});
      end
    end
  endtask

  task automatic test_basic();
    logic [68:0] e, o;
    sel = 0; mode = 0; rdy[0] = 1'b1;
    kick();
    total++;
    if (busy[0] !== 1'b1 || strb[0] !== 1'b1) begin
      bad++; $display("FAIL basic_first_strobe: busy %b strobe %b want 1 1", busy[0], strb[0]);
    end
    finish_sweep();
    total++;
    if (ndone !== 1 || done_cyc !== 76) begin
      bad++; $display("FAIL basic_done: %0d done at cycle %0d, want 1 at 76", ndone, done_cyc);
    end
    total++;
    if (expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL basic_count: exp %0d obs %0d, want 25", expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL basic_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL basic_idle: busy %b want 0", busy[0]); end
  endtask

  task automatic test_stall();
    logic [68:0] e, o;
    sel = 0; mode = 0; rdy[0] = 1'b1;
    kick();
    for (int i = 0; i < 200 && !(ov[0] && oidx[0] == 5'd7); i++) tick();
    rdy[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (ov[0] !== 1'b1 || strb[0] !== 1'b0 || oidx[0] !== 5'd7 || olane[0] !== pat(5'd7)) begin
        bad++;
        $display("FAIL stall_hold: valid %b strobe %b idx %0d lane %h want 1 0 7 %h", ov[0], strb[0], oidx[0], olane[0], pat(5'd7));
      end
      tick();
    end
    rdy[0] = 1'b1;
    finish_sweep();
    total++;
    if (ndone !== 1 || done_cyc !== 86) begin
      bad++; $display("FAIL stall_done: %0d done at cycle %0d, want 1 at 86", ndone, done_cyc);
    end
    total++;
    if (expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL stall_count: exp %0d obs %0d, want 25", expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [68:0] e, o;
    sel = 0; mode = 0; rdy[0] = 1'b1;
    kick();
    while (cyc < 20) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    finish_sweep();
    total++;
    if (ndone !== 1 || done_cyc !== 76 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL restart_ignored: %0d done at cycle %0d busy %b, want 1 at 76 busy 0", ndone, done_cyc, busy[0]);
    end
    total++;
    if (expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL restart_count: exp %0d obs %0d, want 25", expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL restart_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [68:0] e, o;
    sel = 0; mode = 0; rdy[0] = 1'b1;
    kick();
    for (int i = 0; i < 200 && !(ov[0] && oidx[0] == 5'd12); i++) tick();
    rdy[0] = 1'b0;
    tick();
    tick();
    total++;
    if (ov[0] !== 1'b1 || oidx[0] !== 5'd12) begin
      bad++; $display("FAIL mid_reach: valid %b idx %0d want 1 12", ov[0], oidx[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({strb[0], ridx[0], ov[0], olane[0], oidx[0], busy[0], done[0]} !== 78'd0) begin
      bad++; $display("FAIL mid_reset_vals: got %h want 0", {strb[0], ridx[0], ov[0], olane[0], oidx[0], busy[0], done[0]});
    end
`ifdef LANE_SEQ_PARITY_EN
    total++;
    if (par[0] !== 64'd0) begin bad++; $display("FAIL mid_reset_parity: got %h want 0", par[0]); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    repeat (3) tick();
    total++;
    if (ndone !== 0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL mid_abort: done count %0d busy %b want 0 0", ndone, busy[0]);
    end
    kick();
    finish_sweep();
    total++;
    if (obsq.size() == 0 || obsq[0][68:64] !== 5'd0) begin
      bad++; $display("FAIL mid_restart_idx: first obs count %0d, want lane 0 first", obsq.size());
    end
    total++;
    if (ndone !== 1 || done_cyc !== 76 || expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL mid_restart: %0d done at %0d, exp %0d obs %0d, want 1 at 76 with 25", ndone, done_cyc, expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL mid_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
  endtask

  task automatic test_lat3();
    logic [68:0] e, o;
    sel = 1; mode = 0; rdy[1] = 1'b1;
    kick();
    finish_sweep();
    total++;
    if (ndone !== 1 || done_cyc !== 126) begin
      bad++; $display("FAIL lat3_done: %0d done at cycle %0d, want 1 at 126", ndone, done_cyc);
    end
    total++;
    if (mingap < 3) begin bad++; $display("FAIL lat3_gap: min low cycles %0d, want >= 3", mingap); end
    total++;
    if (expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL lat3_count: exp %0d obs %0d, want 25", expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL lat3_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
  endtask

  task automatic test_parity();
    logic [68:0] e, o;
    sel = 0; mode = 1; rdy[0] = 1'b1;
    kick();
    finish_sweep();
    total++;
    if (ndone !== 1 || done_cyc !== 76) begin
      bad++; $display("FAIL onehot_done: %0d done at cycle %0d, want 1 at 76", ndone, done_cyc);
    end
`ifdef LANE_SEQ_PARITY_EN
    total++;
    if (done_par !== 64'h1FF_FFFF) begin bad++; $display("FAIL parity_done: got %h want 1ffffff", done_par); end
    total++;
    if (par[0] !== 64'h1FF_FFFF) begin bad++; $display("FAIL parity_hold: got %h want 1ffffff", par[0]); end
`endif
    total++;
    if (expq.size() != 25 || obsq.size() != 25) begin
      bad++; $display("FAIL onehot_count: exp %0d obs %0d, want 25", expq.size(), obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL onehot_lane: got %0d/%h want %0d/%h", o[68:64], o[63:0], e[68:64], e[63:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_lat3();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
